// File: rtl/spi_agc_pkg.sv
// spi_agc_pkg: shared types and constants for the AGC SPI master.
//   state_t    - frame sequencer states
//   FRAME_BITS - bits per SPI frame (8 instruction + 8 data)
//   MODE_SPI   - control_mode encoding that enables SPI frames
`timescale 1ns/1ps
package spi_agc_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      GAP   = 3'd4
   } state_t;

   localparam int unsigned FRAME_BITS = 16;
   localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
   localparam int unsigned CNT_W      = 8;
   localparam int unsigned BYTE_W     = 8;
   localparam logic [1:0]  MODE_SPI   = 2'b01;

endpackage

// File: rtl/spi_agc_clkgen.sv
// spi_agc_clkgen: SCLK half-period counter for the AGC SPI master.
// Ports:
//   main_clk, reg_reset_n - clock, async active-low reset
//   en                    - count enable (high only while shifting)
//   sclk_rise_c           - last main_clk cycle of the low half (sclk rises next)
//   sclk_fall_c           - last main_clk cycle of the high half (sclk falls next)
`timescale 1ns/1ps
module spi_agc_clkgen
   import spi_agc_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic main_clk,
   input  logic reg_reset_n,
   input  logic en,
   output logic sclk_rise_c,
   output logic sclk_fall_c
);

   logic [CNT_W-1:0] half_cnt;
   logic             phase;
   logic             half_end;

   assign half_end    = en && (half_cnt == CNT_W'(CLK_DIV - 1));
   assign sclk_rise_c = half_end && !phase;
   assign sclk_fall_c = half_end &&  phase;

   // Counter restarts from the low half whenever shifting is not active.
   always_ff @(posedge main_clk or negedge reg_reset_n) begin
      if (!reg_reset_n) begin
         half_cnt <= '0;
         phase    <= 1'b0;
      end else if (!en) begin
         half_cnt <= '0;
         phase    <= 1'b0;
      end else if (half_end) begin
         half_cnt <= '0;
         phase    <= !phase;
      end else begin
         half_cnt <= half_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/spi_agc_master.sv
// spi_agc_master: SPI shift engine for the AGC gain devices.
// Runs one 16-bit frame (instruction byte, then data byte) per start edge on
// the chip select of channel A or B, SPI mode 0, MSB first.
// Ports:
//   main_clk, reg_reset_n     - clock, async active-low reset
//   control_mode              - 2'b01 enables new frames
//   spi_mode                  - instruction byte, bit0 = 1 read / 0 write
//   spi_dataA, spi_dataB      - write data for channel A / B
//   channel                   - 0 = A, 1 = B
//   start                     - rising edge requests a frame
//   read_data                 - last byte captured in a read frame
//   busy, done                - frame in progress / one-cycle end pulse
//   sclk, mosi, miso          - SPI bus
//   cs_a_n, cs_b_n            - active-low chip selects
//   sdio_oe                   - SDIO drive enable (only with SPI_AGC_3WIRE_EN)
// Build option: define SPI_AGC_3WIRE_EN for 3-wire (shared SDIO) operation.
`timescale 1ns/1ps
module spi_agc_master
   import spi_agc_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned CS_GAP  = 8
) (
   input  logic       main_clk,
   input  logic       reg_reset_n,
   input  logic [1:0] control_mode,
   input  logic [7:0] spi_mode,
   input  logic [7:0] spi_dataA,
   input  logic [7:0] spi_dataB,
   input  logic       channel,
   input  logic       start,
   output logic [7:0] read_data,
   output logic       busy,
   output logic       done,
   output logic       sclk,
   output logic       mosi,
   input  logic       miso,
   output logic       cs_a_n,
   output logic       cs_b_n
`ifdef SPI_AGC_3WIRE_EN
   ,
   output logic       sdio_oe
`endif
);

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [BIT_W-1:0]      bit_cnt, bit_nxt;
   logic [FRAME_BITS-1:0] shreg, shreg_nxt;
   logic [BYTE_W-1:0]     rx, rx_nxt;
   logic [BYTE_W-1:0]     read_data_nxt;
   logic                  rd_q, rd_nxt;
   logic                  start_q;
   logic                  accept;
   logic                  busy_nxt, done_nxt, sclk_nxt, mosi_nxt;
   logic                  cs_a_nxt, cs_b_nxt;
   logic                  sclk_rise_c, sclk_fall_c;
`ifdef SPI_AGC_3WIRE_EN
   logic                  oe_nxt;
`endif

   // Rising edge of the start level, honoured only when idle and in SPI mode.
   assign accept = start && !start_q && (state == IDLE) && (control_mode == MODE_SPI);

   spi_agc_clkgen #(
      .CLK_DIV (CLK_DIV)
   ) u_clkgen (
      .main_clk    (main_clk),
      .reg_reset_n (reg_reset_n),
      .en          (state == SHIFT),
      .sclk_rise_c (sclk_rise_c),
      .sclk_fall_c (sclk_fall_c)
   );

   // State and output registers.
   always_ff @(posedge main_clk or negedge reg_reset_n) begin
      if (!reg_reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         rx        <= '0;
         rd_q      <= 1'b0;
         start_q   <= 1'b0;
         read_data <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sclk      <= 1'b0;
         mosi      <= 1'b0;
         cs_a_n    <= 1'b1;
         cs_b_n    <= 1'b1;
`ifdef SPI_AGC_3WIRE_EN
         sdio_oe   <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         bit_cnt   <= bit_nxt;
         shreg     <= shreg_nxt;
         rx        <= rx_nxt;
         rd_q      <= rd_nxt;
         start_q   <= start;
         read_data <= read_data_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         sclk      <= sclk_nxt;
         mosi      <= mosi_nxt;
         cs_a_n    <= cs_a_nxt;
         cs_b_n    <= cs_b_nxt;
`ifdef SPI_AGC_3WIRE_EN
         sdio_oe   <= oe_nxt;
`endif
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      bit_nxt       = bit_cnt;
      shreg_nxt     = shreg;
      rx_nxt        = rx;
      rd_nxt        = rd_q;
      read_data_nxt = read_data;
      busy_nxt      = busy;
      done_nxt      = 1'b0;
      sclk_nxt      = sclk;
      mosi_nxt      = mosi;
      cs_a_nxt      = cs_a_n;
      cs_b_nxt      = cs_b_n;
`ifdef SPI_AGC_3WIRE_EN
      oe_nxt        = sdio_oe;
`endif

      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = SETUP;
               cnt_nxt   = '0;
               rd_nxt    = spi_mode[0];
               rx_nxt    = '0;
               // Data byte is zero-filled for reads so mosi idles low.
               shreg_nxt = {spi_mode,
                            spi_mode[0] ? BYTE_W'(0) : (channel ? spi_dataB : spi_dataA)};
               mosi_nxt  = spi_mode[7];
               busy_nxt  = 1'b1;
               cs_a_nxt  = channel;
               cs_b_nxt  = !channel;
`ifdef SPI_AGC_3WIRE_EN
               oe_nxt    = 1'b1;
`endif
            end
         end

         SETUP: begin
            if (cnt == CNT_W'(CLK_DIV - 1)) begin
               state_nxt = SHIFT;
               cnt_nxt   = '0;
               bit_nxt   = '0;
            end else begin
               cnt_nxt   = cnt + CNT_W'(1);
            end
         end

         SHIFT: begin
            if (sclk_rise_c) begin
               sclk_nxt = 1'b1;
               // Upper half of the bit counter marks the data phase.
               if (rd_q && bit_cnt[BIT_W-1]) begin
                  rx_nxt = {rx[BYTE_W-2:0], miso};
               end
            end
            if (sclk_fall_c) begin
               sclk_nxt  = 1'b0;
               mosi_nxt  = shreg[FRAME_BITS-2];
               shreg_nxt = {shreg[FRAME_BITS-2:0], 1'b0};
               bit_nxt   = bit_cnt + BIT_W'(1);
`ifdef SPI_AGC_3WIRE_EN
               // Release SDIO after the last instruction bit of a read.
               if (rd_q && (bit_cnt == BIT_W'(FRAME_BITS / 2 - 1))) begin
                  oe_nxt = 1'b0;
               end
`endif
               if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
                  state_nxt = HOLD;
                  cnt_nxt   = '0;
               end
            end
         end

         HOLD: begin
            if (cnt == CNT_W'(CLK_DIV - 1)) begin
               state_nxt = GAP;
               cnt_nxt   = '0;
               cs_a_nxt  = 1'b1;
               cs_b_nxt  = 1'b1;
               done_nxt  = 1'b1;
               if (rd_q) begin
                  read_data_nxt = rx;
               end
`ifdef SPI_AGC_3WIRE_EN
               oe_nxt    = 1'b0;
`endif
            end else begin
               cnt_nxt   = cnt + CNT_W'(1);
            end
         end

         GAP: begin
            if (cnt == CNT_W'(CS_GAP - 1)) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               busy_nxt  = 1'b0;
            end else begin
               cnt_nxt   = cnt + CNT_W'(1);
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_spi_agc_master.sv
// tb_spi_agc_master: directed self-checking bench for spi_agc_master
// (CLK_DIV=2, CS_GAP=8). Cycle n counts main_clk cycles after the start edge cycle.
`timescale 1ns/1ps
module tb_spi_agc_master;

   logic       main_clk;
   logic       reg_reset_n;
   logic [1:0] control_mode;
   logic [7:0] spi_mode;
   logic [7:0] spi_dataA;
   logic [7:0] spi_dataB;
   logic       channel;
   logic       start;
   logic [7:0] read_data;
   logic       busy;
   logic       done;
   logic       sclk;
   logic       mosi;
   logic       miso;
   logic       cs_a_n;
   logic       cs_b_n;
`ifdef SPI_AGC_3WIRE_EN
   logic       sdio_oe;
`endif

   int errors;
   int checks;

   // Observations from run_frame
   logic [15:0] obs_word;
   logic [7:0]  obs_rd_done;
   int          obs_rises, obs_falls, obs_unstable, obs_done, obs_done_cnt;
   int          obs_busy_fall, obs_other_low, obs_sel_low1, obs_busy1, obs_data_mosi;

   spi_agc_master #(
      .CLK_DIV (2),
      .CS_GAP  (8)
   ) dut (
      .main_clk     (main_clk),
      .reg_reset_n  (reg_reset_n),
      .control_mode (control_mode),
      .spi_mode     (spi_mode),
      .spi_dataA    (spi_dataA),
      .spi_dataB    (spi_dataB),
      .channel      (channel),
      .start        (start),
      .read_data    (read_data),
      .busy         (busy),
      .done         (done),
      .sclk         (sclk),
      .mosi         (mosi),
      .miso         (miso),
      .cs_a_n       (cs_a_n),
      .cs_b_n       (cs_b_n)
`ifdef SPI_AGC_3WIRE_EN
      ,
      .sdio_oe      (sdio_oe)
`endif
   );

   initial main_clk = 1'b0;
   always #5 main_clk = !main_clk;

   // Issue a start edge and observe one full frame; miso plays a mode-0 slave.
   task automatic run_frame(input logic [7:0] rd_byte, input logic sel);
      logic psclk, pmosi;
      start = 1'b0;
      miso  = 1'b0;
      @(posedge main_clk); #1;
      obs_word = '0; obs_rd_done = 8'h00;
      obs_rises = 0; obs_falls = 0; obs_unstable = 0; obs_done = -1; obs_done_cnt = 0;
      obs_busy_fall = -1; obs_other_low = 0; obs_sel_low1 = 0; obs_busy1 = 0; obs_data_mosi = 0;
      psclk = sclk; pmosi = mosi;
      start = 1'b1;
      for (int n = 1; n <= 150; n++) begin
         @(posedge main_clk); #1;
         if (n == 1) begin
            obs_sel_low1 = sel ? int'(!cs_b_n) : int'(!cs_a_n);
            obs_busy1    = int'(busy);
         end
         if (sel ? !cs_a_n : !cs_b_n) obs_other_low++;
         if (!psclk && sclk) begin
            obs_rises++;
            obs_word = {obs_word[14:0], mosi};
            if (mosi !== pmosi) obs_unstable++;
            if (obs_rises > 8 && mosi) obs_data_mosi++;
         end
         if (psclk && !sclk) begin
            obs_falls++;
            if (obs_falls >= 8 && obs_falls <= 15) miso = rd_byte[15 - obs_falls];
         end
         if (done) begin
            obs_done_cnt++;
            if (obs_done < 0) begin
               obs_done    = n;
               obs_rd_done = read_data;
            end
         end
         if (!busy && n > 1) begin
            obs_busy_fall = n;
            break;
         end
         psclk = sclk; pmosi = mosi;
      end
      start = 1'b0;
   endtask

   task automatic test_reset;
      reg_reset_n = 1'b0; control_mode = 2'b01; spi_mode = 8'h00;
      spi_dataA = 8'h00; spi_dataB = 8'h00; channel = 1'b0; start = 1'b0; miso = 1'b0;
      repeat (3) @(posedge main_clk);
      #1;
      checks++; if (read_data !== 8'h00) begin errors++; $display("FAIL reset_read_data: got %h expected 00", read_data); end
      checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (sclk !== 1'b0)       begin errors++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
      checks++; if (mosi !== 1'b0)       begin errors++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
      checks++; if ({cs_a_n, cs_b_n} !== 2'b11) begin errors++; $display("FAIL reset_cs: got %b expected 11", {cs_a_n, cs_b_n}); end
      @(negedge main_clk); reg_reset_n = 1'b1;
      repeat (2) @(posedge main_clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
   endtask

   task automatic test_write;
      control_mode = 2'b01; spi_mode = 8'hAA; spi_dataA = 8'hF3; spi_dataB = 8'h11; channel = 1'b0;
      run_frame(8'h00, 1'b0);
      checks++; if (obs_word !== 16'hAAF3) begin errors++; $display("FAIL write_mosi_word: got %h expected aaf3", obs_word); end
      checks++; if (obs_rises !== 16)      begin errors++; $display("FAIL write_sclk_rises: got %0d expected 16", obs_rises); end
      checks++; if (obs_unstable !== 0)    begin errors++; $display("FAIL write_mosi_stable: got %0d changes expected 0", obs_unstable); end
      checks++; if (obs_other_low !== 0)   begin errors++; $display("FAIL write_cs_b_idle: got %0d low cycles expected 0", obs_other_low); end
      checks++; if (obs_sel_low1 !== 1 || obs_busy1 !== 1) begin errors++; $display("FAIL write_accept_cycle1: got cs_low=%0d busy=%0d expected 1 1", obs_sel_low1, obs_busy1); end
      checks++; if (obs_done !== 69)       begin errors++; $display("FAIL write_done_cycle: got %0d expected 69", obs_done); end
      checks++; if (obs_done_cnt !== 1)    begin errors++; $display("FAIL write_done_width: got %0d expected 1", obs_done_cnt); end
      checks++; if (obs_rd_done !== 8'h00) begin errors++; $display("FAIL write_read_data: got %h expected 00", obs_rd_done); end
      checks++; if (obs_busy_fall !== 77)  begin errors++; $display("FAIL write_busy_fall: got %0d expected 77", obs_busy_fall); end
   endtask

   task automatic test_read;
      control_mode = 2'b01; spi_mode = 8'h25; spi_dataA = 8'h99; spi_dataB = 8'h77; channel = 1'b1;
      run_frame(8'h5C, 1'b1);
      checks++; if (obs_sel_low1 !== 1)    begin errors++; $display("FAIL read_cs_b_low: got %0d expected 1", obs_sel_low1); end
      checks++; if (obs_other_low !== 0)   begin errors++; $display("FAIL read_cs_a_idle: got %0d low cycles expected 0", obs_other_low); end
      checks++; if (obs_rd_done !== 8'h5C) begin errors++; $display("FAIL read_data_done: got %h expected 5c", obs_rd_done); end
      checks++; if (obs_word !== 16'h2500) begin errors++; $display("FAIL read_mosi_word: got %h expected 2500", obs_word); end
      checks++; if (obs_data_mosi !== 0)   begin errors++; $display("FAIL read_mosi_data_zero: got %0d ones expected 0", obs_data_mosi); end
      checks++; if (obs_done !== 69)       begin errors++; $display("FAIL read_done_cycle: got %0d expected 69", obs_done); end
   endtask

   task automatic test_inhibit;
      int busy_hi, cs_lo;
      busy_hi = 0; cs_lo = 0;
      control_mode = 2'b10; start = 1'b0;
      @(posedge main_clk); #1;
      start = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge main_clk); #1;
         if (busy) busy_hi++;
         if (!cs_a_n || !cs_b_n) cs_lo++;
      end
      checks++; if (busy_hi !== 0) begin errors++; $display("FAIL inhibit_busy: got %0d busy cycles expected 0", busy_hi); end
      checks++; if (cs_lo !== 0)   begin errors++; $display("FAIL inhibit_cs: got %0d cs low cycles expected 0", cs_lo); end
      start = 1'b0; control_mode = 2'b01;
      @(posedge main_clk); #1;
   endtask

   // Start toggling mid-frame, edges during GAP, held level, minimum cs gap.
   task automatic test_back_to_back;
      int fall_cyc[3], rise_cyc[3], nf, nr, busy_rises, first_done, cs_b_lo;
      logic pcs, pbusy;
      nf = 0; nr = 0; busy_rises = 0; first_done = -1; cs_b_lo = 0;
      for (int i = 0; i < 3; i++) begin fall_cyc[i] = -1; rise_cyc[i] = -1; end
      control_mode = 2'b01; spi_mode = 8'h3C; spi_dataA = 8'h81; spi_dataB = 8'h42; channel = 1'b0;
      start = 1'b0;
      @(posedge main_clk); #1;
      pcs = cs_a_n; pbusy = busy;
      for (int n = 0; n < 260; n++) begin
         if      (n < 10)  start = 1'b1;
         else if (n < 20)  start = 1'b0;
         else if (n < 30)  start = 1'b1;
         else if (n < 40)  start = 1'b0;
         else if (n < 74)  start = 1'b1;
         else if (n < 76)  start = 1'b0;
         else if (n < 100) start = 1'b1;
         else if (n == 100) start = 1'b0;
         else if (n < 176) start = 1'b1;
         else if (n < 178) start = 1'b0;
         else              start = 1'b1;
         control_mode = (n >= 20 && n < 60) ? 2'b11 : 2'b01;
         @(posedge main_clk); #1;
         if (pcs && !cs_a_n) begin if (nf < 3) fall_cyc[nf] = n + 1; nf++; end
         if (!pcs && cs_a_n) begin if (nr < 3) rise_cyc[nr] = n + 1; nr++; end
         if (!pbusy && busy) busy_rises++;
         if (done && first_done < 0) first_done = n + 1;
         if (!cs_b_n) cs_b_lo++;
         pcs = cs_a_n; pbusy = busy;
      end
      start = 1'b0;
      checks++; if (nf !== 3)          begin errors++; $display("FAIL b2b_frame_count: got %0d expected 3", nf); end
      checks++; if (busy_rises !== 3)  begin errors++; $display("FAIL b2b_busy_rises: got %0d expected 3", busy_rises); end
      checks++; if (first_done !== 69) begin errors++; $display("FAIL b2b_mode_change_done: got %0d expected 69", first_done); end
      checks++; if (fall_cyc[1] !== 102) begin errors++; $display("FAIL b2b_second_frame: got %0d expected 102", fall_cyc[1]); end
      checks++; if (fall_cyc[2] !== 179) begin errors++; $display("FAIL b2b_third_frame: got %0d expected 179", fall_cyc[2]); end
      checks++; if (fall_cyc[2] - rise_cyc[1] !== 9) begin errors++; $display("FAIL b2b_cs_gap: got %0d expected 9", fall_cyc[2] - rise_cyc[1]); end
      checks++; if (cs_b_lo !== 0)     begin errors++; $display("FAIL b2b_cs_b_idle: got %0d expected 0", cs_b_lo); end
      checks++; if (read_data !== 8'h5C) begin errors++; $display("FAIL b2b_read_data_kept: got %h expected 5c", read_data); end
      repeat (10) @(posedge main_clk);
      #1;
   endtask

   task automatic test_reset_mid;
      int rises, act;
      logic psclk, hit;
      rises = 0; act = 0; hit = 1'b0;
      control_mode = 2'b01; spi_mode = 8'hC3; spi_dataA = 8'h00; channel = 1'b0; miso = 1'b1;
      start = 1'b0;
      @(posedge main_clk); #1;
      psclk = sclk;
      start = 1'b1;
      for (int n = 1; n <= 100; n++) begin
         @(posedge main_clk); #1;
         if (!psclk && sclk) rises++;
         psclk = sclk;
         if (rises == 10) begin hit = 1'b1; break; end
      end
      checks++; if (hit !== 1'b1) begin errors++; $display("FAIL rstmid_reach_bit10: got rises=%0d expected 10", rises); end
      #2;
      reg_reset_n = 1'b0; start = 1'b0;
      #1;
      checks++; if (cs_a_n !== 1'b1) begin errors++; $display("FAIL rstmid_cs_a: got %b expected 1", cs_a_n); end
      checks++; if (sclk !== 1'b0)   begin errors++; $display("FAIL rstmid_sclk: got %b expected 0", sclk); end
      checks++; if (busy !== 1'b0 || mosi !== 1'b0) begin errors++; $display("FAIL rstmid_busy_mosi: got %b %b expected 0 0", busy, mosi); end
      @(negedge main_clk); reg_reset_n = 1'b1;
      for (int n = 0; n < 80; n++) begin
         @(posedge main_clk); #1;
         if (!cs_a_n || !cs_b_n || done || busy) act++;
      end
      checks++; if (act !== 0)          begin errors++; $display("FAIL rstmid_no_activity: got %0d active cycles expected 0", act); end
      checks++; if (read_data !== 8'h00) begin errors++; $display("FAIL rstmid_read_data: got %h expected 00", read_data); end
      run_frame(8'hA5, 1'b0);
      checks++; if (obs_rd_done !== 8'hA5) begin errors++; $display("FAIL rstmid_new_frame_data: got %h expected a5", obs_rd_done); end
      checks++; if (obs_done !== 69)       begin errors++; $display("FAIL rstmid_new_frame_done: got %0d expected 69", obs_done); end
      checks++; if (obs_word !== 16'hC300) begin errors++; $display("FAIL rstmid_new_frame_mosi: got %h expected c300", obs_word); end
   endtask

`ifdef SPI_AGC_3WIRE_EN
   task automatic test_3wire;
      int falls, fall8, oe_fall, oe_hi_after, n_done;
      logic psclk, oe_c1, oe_done;
      falls = 0; fall8 = -1; oe_fall = -1; oe_hi_after = 0; n_done = -1; oe_c1 = 1'b0; oe_done = 1'b1;
      control_mode = 2'b01; spi_mode = 8'h25; channel = 1'b0; miso = 1'b0; start = 1'b0;
      @(posedge main_clk); #1;
      psclk = sclk;
      start = 1'b1;
      for (int n = 1; n <= 100; n++) begin
         @(posedge main_clk); #1;
         if (n == 1) oe_c1 = sdio_oe;
         if (psclk && !sclk) begin falls++; if (falls == 8) fall8 = n; end
         if (!sdio_oe && oe_fall < 0) oe_fall = n;
         if (oe_fall >= 0 && sdio_oe) oe_hi_after++;
         if (done) begin n_done = n; oe_done = sdio_oe; break; end
         psclk = sclk;
      end
      start = 1'b0;
      checks++; if (oe_c1 !== 1'b1)  begin errors++; $display("FAIL 3w_oe_setup: got %b expected 1", oe_c1); end
      checks++; if (oe_fall !== 35)  begin errors++; $display("FAIL 3w_oe_fall_cycle: got %0d expected 35", oe_fall); end
      checks++; if (fall8 !== oe_fall) begin errors++; $display("FAIL 3w_oe_at_sclk_fall: got %0d expected %0d", oe_fall, fall8); end
      checks++; if (oe_hi_after !== 0 || oe_done !== 1'b0 || n_done !== 69) begin errors++; $display("FAIL 3w_oe_low_to_cs_rise: got hi=%0d oe=%b done=%0d expected 0 0 69", oe_hi_after, oe_done, n_done); end
      repeat (12) @(posedge main_clk);
      #1;
   endtask
`endif

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_write();
      test_read();
      test_inhibit();
      test_back_to_back();
      test_reset_mid();
`ifdef SPI_AGC_3WIRE_EN
      test_3wire();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
